// File: rtl/count_uart_tx_pkg.sv
// count_uart_tx shared types and helpers.
// Frame state, frame length and parameter legality.
package count_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned frame_len(
    input int unsigned div,
    input int unsigned sb
  );
    return (1 + DATA_BITS + sb) * div;
  endfunction

  function automatic bit params_ok(
    input int unsigned div,
    input int unsigned sb
  );
    return (div >= 2) && (div <= 65535) &&
           ((sb == 1) || (sb == 2));
  endfunction

endpackage

// File: rtl/count_uart_tx_baud_tick.sv
// Bit-period divider for count_uart_tx.
// Tick marks the last clock of every bit period.
module baud_tick #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // free-running 0..DIVISOR-1, realigned on frame acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Byte serializer for counter values, 8N1/8N2.
// FSM runs one cycle ahead of the registered tx/busy.
module count_uart_tx
  import count_uart_tx_pkg::*;
#(
  parameter int unsigned DIVISOR   = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  if (!params_ok(DIVISOR, STOP_BITS)) begin : g_bad_params
    $error("count_uart_tx: illegal DIVISOR or STOP_BITS");
  end

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       tick;
  logic       last_stop;
  logic       accept;

  assign last_stop = (state == STOP) && tick &&
                     (bit_idx == 3'(STOP_BITS - 1));
  assign in_ready  = (state == IDLE) || last_stop;
  assign accept    = in_valid && in_ready;

  baud_tick #(
    .DIVISOR(DIVISOR)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

  // frame sequencer with registered line and busy outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      tx   <= 1'b1;
      busy <= (state != IDLE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            shift   <= in_data;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (tick) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (tick) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              bit_idx <= '0;
              if (accept) begin
                shift <= in_data;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx.
// Two instances: 8N1 at /4 and 8N2 at /2.
module tb_count_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d4, d2;
  logic       v4, v2;
  logic       r4, r2;
  logic       tx4, tx2;
  logic       b4, b2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  count_uart_tx #(
    .DIVISOR  (4),
    .STOP_BITS(1)
  ) dut4 (
    .clk     (clk),
    .rst     (rst),
    .in_data (d4),
    .in_valid(v4),
    .in_ready(r4),
    .tx      (tx4),
    .busy    (b4)
  );

  count_uart_tx #(
    .DIVISOR  (2),
    .STOP_BITS(2)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .in_data (d2),
    .in_valid(v2),
    .in_ready(r2),
    .tx      (tx2),
    .busy    (b2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b, expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag,
                      input int obs,
                      input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  // Called at j=0 (just after handshake edge k).
  // Checks edges k+1..k+40 of a /4 8N1 frame.
  task automatic frame4(input logic [7:0] b,
                        input logic hold);
    logic e;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j <= 4) e = 1'b0;
      else if (j <= 36) e = b[(j - 5) / 4];
      else e = 1'b1;
      chk("tx4", tx4, e);
      chk("busy4", b4, 1'b1);
      chk("rdy4", r4,
          (j == 39) || ((j == 40) && !hold));
    end
  endtask

  task automatic idle4(input string tag);
    chk({tag, "_tx"}, tx4, 1'b1);
    chk({tag, "_busy"}, b4, 1'b0);
    chk({tag, "_rdy"}, r4, 1'b1);
  endtask

  initial begin
    int         s;
    int         prev_s;
    int         off;
    int         nframes;
    bit         in_frame;
    bit         hs;
    logic [7:0] rx;
    logic [7:0] exp_b;
    logic [7:0] cnt;

    rst = 1'b0;
    v4  = 1'b0;
    v2  = 1'b0;
    d4  = 8'h00;
    d2  = 8'h00;
    step();
    step();
    idle4("reset");
    chk("reset_tx2", tx2, 1'b1);
    chk("reset_busy2", b2, 1'b0);
    chk("reset_rdy2", r2, 1'b1);
    rst = 1'b1;
    step();

    // single 0x55 frame
    v4 = 1'b1;
    d4 = 8'h55;
    chk("t1_rdy_pre", r4, 1'b1);
    step();
    v4 = 1'b0;
    chk("t1_j0_tx", tx4, 1'b1);
    chk("t1_j0_busy", b4, 1'b0);
    chk("t1_j0_rdy", r4, 1'b0);
    frame4(8'h55, 1'b0);
    step();
    idle4("t1_end");

    // back-to-back 0x00 then 0x01
    v4 = 1'b1;
    d4 = 8'h00;
    step();
    d4 = 8'h01;
    frame4(8'h00, 1'b1);
    v4 = 1'b0;
    frame4(8'h01, 1'b0);
    step();
    idle4("t2_end");

    // data changed right after handshake
    v4 = 1'b1;
    d4 = 8'hA5;
    step();
    v4 = 1'b0;
    d4 = 8'hFF;
    frame4(8'hA5, 1'b0);
    step();
    idle4("t3_end");

    // reset in the middle of a frame
    v4 = 1'b1;
    d4 = 8'h3B;
    step();
    v4 = 1'b0;
    repeat (15) step();
    rst = 1'b0;
    step();
    chk("t4_rst_tx", tx4, 1'b1);
    chk("t4_rst_busy", b4, 1'b0);
    rst = 1'b1;
    step();
    idle4("t4_rel");
    v4 = 1'b1;
    d4 = 8'hC3;
    step();
    v4 = 1'b0;
    frame4(8'hC3, 1'b0);
    step();
    idle4("t4_end");

    // reset and valid on the same edge
    rst = 1'b0;
    v4  = 1'b1;
    d4  = 8'h00;
    step();
    chk("t6_tx", tx4, 1'b1);
    chk("t6_busy", b4, 1'b0);
    rst = 1'b1;
    v4  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_hold_tx", tx4, 1'b1);
      chk("t6_hold_busy", b4, 1'b0);
    end

    // counter-driven stream into /2 8N2
    cnt      = 8'h00;
    exp_b    = 8'h00;
    prev_s   = -1;
    s        = 0;
    nframes  = 0;
    in_frame = 1'b0;
    rx       = 8'h00;
    v2       = 1'b1;
    d2       = cnt;
    hs       = r2;
    for (int t = 0; t < 160; t++) begin
      step();
      if (hs) begin
        cnt = cnt + 8'd1;
        d2  = cnt;
      end
      hs = r2;
      if (!in_frame) begin
        if (tx2 == 1'b0) begin
          in_frame = 1'b1;
          s        = t;
          if (prev_s >= 0) chkv("t5_period", t - prev_s, 22);
          prev_s = t;
        end
      end else begin
        off = t - s;
        if ((off % 2 == 0) && off >= 2 && off <= 16)
          rx[off / 2 - 1] = tx2;
        if (off == 18 || off == 20 || off == 21)
          chk("t5_stop", tx2, 1'b1);
        if (off == 21) begin
          chkv("t5_byte", int'(rx), int'(exp_b));
          exp_b    = exp_b + 8'd1;
          nframes++;
          in_frame = 1'b0;
        end
      end
    end
    v2 = 1'b0;
    chkv("t5_frames", nframes, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/count_uart_tx.md
# count_uart_tx

Byte serializer that sits directly downstream of the 8-bit free-running counter and turns each accepted count value into an asynchronous 8N1/8N2 serial frame on a single line. It provides a valid/ready input handshake so the counter (or a sampling register after it) can offer values at any rate. Frames go out LSB first, gap-free when input is continuously valid. It is the observable output stage for counter-driven test sequences.

## Interface
Parameters:
- DIVISOR, 4, clock cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-low (sampled on rising clk, 0 = reset).
- in_data  in  8  byte to transmit, typically the counter's count value.
- in_valid  in  1  in_data is offered.
- in_ready  out  1  block accepts in_data this cycle; transfer when in_valid && in_ready at a rising edge.
- tx  out  1  serial line; idle high; registered.
- busy  out  1  high from the cycle after acceptance until the frame's final stop-bit cycle, inclusive.

## Operation
- States: IDLE, START, DATA, STOP.
- Reset (rst==0 at an edge): state=IDLE, tx=1, busy=0, in_ready=1 after the edge, divider and bit index cleared, shift register cleared.
- IDLE: tx=1, in_ready=1. On handshake, latch in_data into shift register, go to START.
- START: tx=0 for DIVISOR cycles, then DATA.
- DATA: tx=shift[0] for DIVISOR cycles per bit; shift right after each bit; after bit 7 go to STOP.
- STOP: tx=1 for STOP_BITS*DIVISOR cycles, then IDLE. in_ready is also 1 in the last STOP cycle; a handshake there goes straight to START, giving back-to-back frames with no idle cycles.
- in_ready is a function of registered state only; no combinational path from in_valid to in_ready.
- in_data is captured only at the handshake; later changes do not affect the frame in flight.
- in_valid while busy (except last STOP cycle): ignored, no transfer; the source holds its data.
- Divider counter: width ceil(log2(DIVISOR)), counts 0..DIVISOR-1, wraps; bit index 3 bits, 0..7.

## Timing
- Handshake at edge k: tx goes low after edge k+1 (1-cycle latency).
- Data bit i (i=0..7) is driven from edge k+1+(1+i)*DIVISOR for DIVISOR cycles.
- Stop bit(s) start at edge k+1+9*DIVISOR; frame occupies (9+STOP_BITS)*DIVISOR cycles.
- Back-to-back: next start bit begins exactly (9+STOP_BITS)*DIVISOR cycles after the previous one.
- Reset mid-frame: at the reset edge tx returns to 1, frame abandoned, latched byte discarded; no partial stop bit is guaranteed.
- Reset and handshake at the same edge: reset wins, no transfer.

## Structure
- Shared package: state enum (IDLE, START, DATA, STOP), frame-length constant function (9+STOP_BITS)*DIVISOR, parameter legality checks for DIVISOR and STOP_BITS.
- One sub-module: baud_tick (divider counter, DIVISOR parameter, sync active-low rst, restart input, 1-cycle tick output on the last cycle of each bit period).
- Top holds the FSM, shift register, bit index, and output registers.

## Test plan
- DIVISOR=4, STOP_BITS=1, send 0x55 -> tx: 4 cycles 0, then 1,0,1,0,1,0,1,0 each 4 cycles, 4 cycles 1, then idle high; busy high for exactly 40 cycles.
- in_valid held high with 0x00 then 0x01 -> two 40-cycle frames, second start bit exactly 40 cycles after first, no idle gap; in_ready high only in IDLE and last stop cycle.
- in_data changed from 0xA5 to 0xFF one cycle after handshake -> transmitted bits decode as 0xA5.
- rst=0 asserted at cycle 15 of a frame -> tx=1 on the next cycle, busy=0, in_ready=1 after release; next handshake produces a clean full frame.
- Driven by the counter (count 0,1,2,... sampled on each in_ready) with DIVISOR=2, STOP_BITS=2 -> bench receiver model decodes strictly increasing byte values, 22 cycles per frame, no framing errors.
- Simultaneous rst=0 and in_valid=1 in IDLE -> no frame, tx stays 1.
